suma_carga_multi: RTL
=====================

// Module: suma_carga_multi
// PURPOSE
//  Multi-battery charge totaliser; parametrised successor of the 2x4-bit combinational charge adder.
//  Captures N_BATERIAS packed charge readings plus an enable mask through a valid/ready handshake.
//  Accumulates enabled channels serially, one channel per clock, through one shared adder.
//  Returns the exact total, the active-channel count and a per-channel low-charge alarm,
//  held until the consumer (display / pack-management logic) accepts the result.
// PARAMETERS
//  N_BATERIAS   4  channel count, >=2
//  ANCHO        4  bits per channel charge reading
//  UMBRAL       3  low-charge threshold; an enabled channel with charge < UMBRAL raises its alarm bit
//  Derived: ANCHO_TOTAL = ANCHO + $clog2(N_BATERIAS); ANCHO_CNT = $clog2(N_BATERIAS+1)
// PORTS
//  clk          in   1                     single clock, rising edge
//  rst_n        in   1                     asynchronous reset, active-low
//  in_valid     in   1                     request carries a valid reading set
//  in_ready     out  1                     block can accept a request (state IDLE)
//  cargas       in   N_BATERIAS*ANCHO      channel i = cargas[i*ANCHO +: ANCHO]
//  mascara      in   N_BATERIAS            bit i=1: channel i is summed and checked
//  out_valid    out  1                     result registers valid
//  out_ready    in   1                     consumer accepts the result
//  carga_total  out  ANCHO_TOTAL           sum of enabled channels; exact, never overflows
//  num_activas  out  ANCHO_CNT             popcount(mascara) of the captured request
//  alarma_baja  out  N_BATERIAS            bit i = mascara[i] & (carga_i < UMBRAL)
// BEHAVIOUR
//  Reset: clk and rst_n as above; polarity and synchronicity are fixed.
//   rst_n=0 -> state IDLE, idx=0, and all output registers cleared immediately.
//   Cleared outputs: out_valid=0, carga_total=0, num_activas=0, alarma_baja=0.
//   Asserting rst_n mid-operation aborts the transaction with no result.
//  FSM IDLE -> SUMA -> HECHO -> IDLE. in_ready = (state==IDLE); out_valid = (state==HECHO).
//  IDLE: on edge with in_valid & in_ready, do the following:
//   - capture cargas and mascara into internal registers;
//   - clear the accumulator, count and alarm; set idx=0; go to SUMA.
//  SUMA: each clock, for the captured channel idx:
//   - if mascara[idx]: acc += carga_idx, cnt += 1, alarma[idx] = (carga_idx < UMBRAL); else no change.
//   - idx increments each clock; after idx = N_BATERIAS-1 is processed, go to HECHO.
//  Latency: out_valid rises exactly N_BATERIAS clocks after the accepting edge.
//   This holds regardless of mascara; there is no early exit.
//  HECHO: carga_total, num_activas and alarma_baja are stable while out_valid=1.
//   Edge with out_ready=1 -> IDLE; out_valid falls and the outputs keep their last values.
//   out_ready low stalls indefinitely; no data loss.
//  Throughput: one request per N_BATERIAS+2 clocks at best.
//   in_ready is low during SUMA and HECHO; in_valid in those states is ignored, not queued.
//  Inputs cargas and mascara may change after acceptance with no effect on the result.
//  Arithmetic: unsigned; acc is ANCHO_TOTAL wide.
//   The maximum sum N*(2^ANCHO-1) always fits; no saturation or wrap occurs.
//  out_ready while not in HECHO is ignored.
// TESTING (defaults N_BATERIAS=4, ANCHO=4, UMBRAL=3; listed ch3..ch0)
//  1 Reset: rst_n=0 -> outputs 0, in_ready=0 during reset; after release in_ready=1, out_valid=0.
//  2 Full load: cargas={F,F,F,F}, mascara=1111 -> carga_total=60 (6'h3C), num_activas=4,
//    alarma_baja=0000; out_valid exactly 4 clocks after accept.
//  3 Masked: cargas={1,2,9,5}, mascara=0101 -> carga_total=7, num_activas=2,
//    alarma_baja=0100; ch1=9 is excluded.
//  4 Backpressure: hold out_ready=0 for 5 clocks and pulse in_valid with new data.
//    -> outputs held, in_ready=0, new request dropped; out_ready=1 -> IDLE next clock.
//  5 Reset mid-SUMA after 2 channels: outputs 0, state IDLE.
//    Next request {3,3,3,3}/1111 -> total 12, alarma 0000.
//  6 Empty mask: any cargas, mascara=0000 -> total 0, activas 0, alarma 0000, latency still 4.

Source files
------------

// File: rtl/suma_carga_multi.sv
// suma_carga_multi: serial multi-battery charge totaliser.
// One shared adder walks the captured channels, one per clock.
module suma_carga_multi #(
  parameter  int N_BATERIAS  = 4,
  parameter  int ANCHO       = 4,
  parameter  int UMBRAL      = 3,
  localparam int ANCHO_TOTAL = ANCHO + $clog2(N_BATERIAS),
  localparam int ANCHO_CNT   = $clog2(N_BATERIAS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_BATERIAS*ANCHO-1:0]   cargas,
  input  logic [N_BATERIAS-1:0]         mascara,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ANCHO_TOTAL-1:0]        carga_total,
  output logic [ANCHO_CNT-1:0]          num_activas,
  output logic [N_BATERIAS-1:0]         alarma_baja
);

  localparam int ANCHO_IDX = $clog2(N_BATERIAS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SUMA  = 2'd1;
  localparam logic [1:0] HECHO = 2'd2;

  logic [1:0]             r_estado;
  logic [ANCHO_IDX-1:0]   r_idx;
  logic [ANCHO-1:0]       r_canal [N_BATERIAS];
  logic [N_BATERIAS-1:0]  r_mascara;
  logic [ANCHO_TOTAL-1:0] r_acc;
  logic [ANCHO_CNT-1:0]   r_cnt;
  logic [N_BATERIAS-1:0]  r_alarma;

  logic                   w_acepta;
  logic                   w_ultimo;
  logic                   w_activo;
  logic                   w_bajo;
  logic [ANCHO-1:0]       w_carga;
  logic [ANCHO_TOTAL-1:0] w_acc_sig;
  logic [ANCHO_CNT-1:0]   w_cnt_sig;
  logic [N_BATERIAS-1:0]  w_alarma_sig;

  // Handshake flags; in_ready is held low while reset is asserted.
  assign in_ready  = (r_estado == IDLE) & rst_n;
  assign out_valid = (r_estado == HECHO);
  assign w_acepta  = (r_estado == IDLE) & in_valid;
  assign w_ultimo  = (r_idx == ANCHO_IDX'(N_BATERIAS - 1));

  // Current channel view and the next accumulator state it produces.
  always_comb begin
    w_carga      = r_canal[r_idx];
    w_activo     = r_mascara[r_idx];
    w_bajo       = (32'(w_carga) < 32'(UMBRAL));
    w_acc_sig    = r_acc;
    w_cnt_sig    = r_cnt;
    w_alarma_sig = r_alarma;
    if (w_activo) begin
      w_acc_sig = r_acc + ANCHO_TOTAL'(w_carga);
      w_cnt_sig = r_cnt + ANCHO_CNT'(1);
      w_alarma_sig[r_idx] = w_bajo;
    end
  end

  // Control FSM: IDLE -> SUMA (fixed N clocks) -> HECHO -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= IDLE;
      r_idx    <= '0;
    end else begin
      unique case (r_estado)
        IDLE: begin
          if (w_acepta) begin
            r_estado <= SUMA;
            r_idx    <= '0;
          end
        end
        SUMA: begin
          r_idx <= r_idx + ANCHO_IDX'(1);
          if (w_ultimo) begin
            r_estado <= HECHO;
            r_idx    <= '0;
          end
        end
        HECHO: begin
          if (out_ready) begin
            r_estado <= IDLE;
          end
        end
        default: begin
          r_estado <= IDLE;
          r_idx    <= '0;
        end
      endcase
    end
  end

  // Request capture and serial accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BATERIAS; i++) begin
        r_canal[i] <= '0;
      end
      r_mascara <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_alarma  <= '0;
    end else if (w_acepta) begin
      for (int i = 0; i < N_BATERIAS; i++) begin
        r_canal[i] <= cargas[i*ANCHO +: ANCHO];
      end
      r_mascara <= mascara;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_alarma  <= '0;
    end else if (r_estado == SUMA) begin
      r_acc    <= w_acc_sig;
      r_cnt    <= w_cnt_sig;
      r_alarma <= w_alarma_sig;
    end
  end

  // Result registers: loaded with the last channel folded in, then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carga_total <= '0;
      num_activas <= '0;
      alarma_baja <= '0;
    end else if ((r_estado == SUMA) && w_ultimo) begin
      carga_total <= w_acc_sig;
      num_activas <= w_cnt_sig;
      alarma_baja <= w_alarma_sig;
    end
  end

endmodule
